instr_encoder: RTL and testbench

- Builds 32-bit RV32I instruction words from decoded fields and writes them in sequence into instruction memory. It is the encode direction of the control decoder.
- Used as the boot-time and test-time program loader of the monocycle core. It is driven by a testbench or a host-side sequencer through a valid/ready field interface.
- Instruction classes use the same 3-bit codes the decoder emits on its ALU-op output.

---
 rtl/instr_encoder_pkg.sv | 25 ++
 rtl/instr_encoder_if.sv | 16 +
 rtl/instr_encoder_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 87 ++++++++
 tb/tb_instr_encoder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encode constants: opcodes, instruction-class codes, loader FSM states.
// Class codes are the same 3-bit values the control decoder drives on its ALU-op output.
package rv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] KIND_R    = 3'b000;
  localparam logic [2:0] KIND_I    = 3'b001;
  localparam logic [2:0] KIND_S    = 3'b010;
  localparam logic [2:0] KIND_L    = 3'b011;
  localparam logic [2:0] KIND_B    = 3'b100;
  localparam logic [2:0] KIND_JALR = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    FULL = 2'b10
  } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Decoded-field bundle with valid/ready handshake between a program sequencer and the encoder.
// The master drives fields and valid; the slave returns ready.
interface instr_encoder_if;
  logic        valid;
  logic        ready;
  logic [2:0]  kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [12:0] imm;

  modport master (output valid, kind, rd, rs1, rs2, funct3, funct7, imm, input ready);
  modport slave  (input valid, kind, rd, rs1, rs2, funct3, funct7, imm, output ready);
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packer: decoded fields in, 32-bit instruction word and legal flag out.
// Latency 0; no handshake of its own.
module instr_pack
  import rv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (kind)
      KIND_R: begin
        word  = {funct7, rs2, rs1, funct3, rd, OP_R};
        legal = 1'b1;
      end
      KIND_I: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_I};
        legal = (imm[12] == imm[11]);
      end
      KIND_L: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_L};
        legal = (imm[12] == imm[11]);
      end
      KIND_JALR: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_JALR};
        legal = (imm[12] == imm[11]);
      end
      KIND_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
        legal = (imm[12] == imm[11]);
      end
      KIND_B: begin
        // Branch offsets are halfword-aligned, so bit 0 is not encoded and must be zero.
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        legal = ~imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes accepted field bundles and writes them sequentially into instruction memory.
// Latency 1 (accept on edge N, write/err visible in cycle N+1); ready drops when idle or memory is full.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                finish_i,
  instr_encoder_if.slave      bus,
  output logic                imem_we_o,
  output logic [ADDR_W-1:0]   imem_addr_o,
  output logic [31:0]         imem_wdata_o,
  output logic [ADDR_W:0]     count_o,
  output logic                busy_o,
  output logic                err_o,
  output logic                done_o
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state;
  state_e          state_nxt;
  logic [ADDR_W:0] ptr;
  logic            accept;
  logic            legal;
  logic [31:0]     word;

  instr_pack u_pack (
    .kind   (bus.kind),
    .rd     (bus.rd),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .imm    (bus.imm),
    .word   (word),
    .legal  (legal)
  );

  assign bus.ready = (state == LOAD);
  assign accept    = bus.valid && bus.ready;
  assign busy_o    = (state != IDLE);
  assign count_o   = ptr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = LOAD;
      // finish wins over filling: a last-slot accept with finish still ends the session.
      LOAD: begin
        if (finish_i)                             state_nxt = IDLE;
        else if (accept && legal && ptr == LAST)  state_nxt = FULL;
      end
      FULL: if (finish_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      ptr          <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      err_o        <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state     <= state_nxt;
      imem_we_o <= accept && legal;
      err_o     <= accept && !legal;
      done_o    <= (state != IDLE) && finish_i;
      if (state == IDLE && start_i) begin
        ptr <= '0;
      end else if (accept && legal) begin
        ptr          <= ptr + ONE;
        imem_addr_o  <= ptr[ADDR_W-1:0];
        imem_wdata_o <= word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: stimulus pushes hand-computed expected responses, per-DUT monitors pop and compare.
module tb_instr_encoder;

  typedef struct packed {
    logic        we;
    logic        err;
    logic        done;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [6:0]  count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, finish_a, valid_a;
  logic start_b, finish_b, valid_b;
  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [12:0] imm;

  instr_encoder_if ifa ();
  instr_encoder_if ifb ();

  assign ifa.valid = valid_a;  assign ifb.valid = valid_b;
  assign ifa.kind = kind;      assign ifb.kind = kind;
  assign ifa.rd = rd;          assign ifb.rd = rd;
  assign ifa.rs1 = rs1;        assign ifb.rs1 = rs1;
  assign ifa.rs2 = rs2;        assign ifb.rs2 = rs2;
  assign ifa.funct3 = f3;      assign ifb.funct3 = f3;
  assign ifa.funct7 = f7;      assign ifb.funct7 = f7;
  assign ifa.imm = imm;        assign ifb.imm = imm;

  logic        we_a, busy_a, err_a, done_a;
  logic [5:0]  addr_a;
  logic [31:0] data_a;
  logic [6:0]  count_a;
  logic        we_b, busy_b, err_b, done_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  count_b;

  instr_encoder #(.ADDR_W(6)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .finish_i(finish_a), .bus(ifa),
    .imem_we_o(we_a), .imem_addr_o(addr_a), .imem_wdata_o(data_a), .count_o(count_a),
    .busy_o(busy_a), .err_o(err_a), .done_o(done_a)
  );

  instr_encoder #(.ADDR_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .finish_i(finish_b), .bus(ifb),
    .imem_we_o(we_b), .imem_addr_o(addr_b), .imem_wdata_o(data_b), .count_o(count_b),
    .busy_o(busy_b), .err_o(err_b), .done_o(done_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic err, input logic done,
                              input logic [5:0] addr, input logic [31:0] data, input logic [6:0] count);
    exp_t e;
    e.we = we; e.err = err; e.done = done; e.addr = addr; e.data = data; e.count = count;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic we, input logic err,
                         input logic done, input logic [5:0] addr, input logic [31:0] data,
                         input logic [6:0] count);
    chk({tag, ".we"},    32'(we),    32'(e.we));
    chk({tag, ".err"},   32'(err),   32'(e.err));
    chk({tag, ".done"},  32'(done),  32'(e.done));
    chk({tag, ".count"}, 32'(count), 32'(e.count));
    if (e.we) begin
      chk({tag, ".addr"}, 32'(addr), 32'(e.addr));
      chk({tag, ".data"}, data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (we_a || err_a || done_a) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon_a unexpected output we=%b err=%b done=%b addr=%h", we_a, err_a, done_a, addr_a);
      end else begin
        compare("mon_a", qa.pop_front(), we_a, err_a, done_a, addr_a, data_a, count_a);
      end
    end
  end

  always @(negedge clk) begin
    if (we_b || err_b || done_b) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon_b unexpected output we=%b err=%b done=%b addr=%h", we_b, err_b, done_b, addr_b);
      end else begin
        compare("mon_b", qb.pop_front(), we_b, err_b, done_b, {4'b0, addr_b}, data_b, {4'b0, count_b});
      end
    end
  end

  // All tasks are entered and left on a falling edge.
  task automatic start_s(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
                      input logic [12:0] im, input bit fin, input exp_t e);
    bit got_rdy;
    kind = k; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
    if (sel) begin valid_b = 1'b1; finish_b = fin; end
    else     begin valid_a = 1'b1; finish_a = fin; end
    got_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? ifb.ready : ifa.ready) begin got_rdy = 1'b1; break; end
      @(negedge clk);
    end
    if (!got_rdy) begin
      checks++; failures++;
      $display("FAIL send_timeout got=ready_low want=ready_high");
    end else begin
      if (sel) qb.push_back(e); else qa.push_back(e);
      @(negedge clk);
    end
    finish_a = 1'b0; finish_b = 1'b0;
  endtask

  task automatic fin(input bit sel, input exp_t e);
    valid_a = 1'b0; valid_b = 1'b0;
    if (sel) begin finish_b = 1'b1; qb.push_back(e); end
    else     begin finish_a = 1'b1; qa.push_back(e); end
    @(negedge clk);
    finish_a = 1'b0; finish_b = 1'b0;
  endtask

  task automatic idle();
    valid_a = 1'b0; valid_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_a = 0; finish_a = 0; valid_a = 0;
    start_b = 0; finish_b = 0; valid_b = 0;
    kind = 0; rd = 0; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; imm = 0;
    repeat (3) @(negedge clk);
    chk("rst.we",    32'(we_a),    0);
    chk("rst.err",   32'(err_a),   0);
    chk("rst.done",  32'(done_a),  0);
    chk("rst.count", 32'(count_a), 0);
    chk("rst.busy",  32'(busy_a),  0);
    chk("rst.ready", 32'(ifa.ready), 0);
    chk("rst.addr",  32'(addr_a),  0);
    chk("rst.data",  data_a,       0);
    rst_n = 1'b1;
    @(negedge clk);

    // Session 1: addi x1,x0,5 then finish alone.
    start_s(0);
    chk("s1.busy",  32'(busy_a),    1);
    chk("s1.ready", 32'(ifa.ready), 1);
    chk("s1.count", 32'(count_a),   0);
    send(0, 3'b001, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 0, mk(1, 0, 0, 6'd0, 32'h00500093, 7'd1));
    idle();
    fin(0, mk(0, 0, 1, 6'd0, 32'h0, 7'd1));
    @(negedge clk);
    chk("s1.busy_after", 32'(busy_a), 0);

    // Session 2: back-to-back legal words, rejects, then accept with finish.
    start_s(0);
    send(0, 3'b000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0,     0, mk(1, 0, 0, 6'd0, 32'h002081B3, 7'd1));
    send(0, 3'b010, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd8,     0, mk(1, 0, 0, 6'd1, 32'h0020A423, 7'd2));
    send(0, 3'b100, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC,  0, mk(1, 0, 0, 6'd2, 32'hFE208EE3, 7'd3));
    send(0, 3'b011, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h1FF8,  0, mk(1, 0, 0, 6'd3, 32'hFF812283, 7'd4));
    send(0, 3'b101, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 13'd0,     0, mk(1, 0, 0, 6'd4, 32'h00008067, 7'd5));
    send(0, 3'b110, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0,     0, mk(0, 1, 0, 6'd0, 32'h0, 7'd5));
    send(0, 3'b001, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800,  0, mk(0, 1, 0, 6'd0, 32'h0, 7'd5));
    send(0, 3'b100, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3,     0, mk(0, 1, 0, 6'd0, 32'h0, 7'd5));
    send(0, 3'b001, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5,     1, mk(1, 0, 1, 6'd5, 32'h00500093, 7'd6));
    idle();
    chk("s2.busy",  32'(busy_a),    0);
    chk("s2.ready", 32'(ifa.ready), 0);
    chk("s2.count", 32'(count_a),   6);

    // Small memory: fill, illegal in last slot must not fill, fifth bundle stalls.
    start_s(1);
    send(1, 3'b001, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 0, mk(1, 0, 0, 6'd0, 32'h00500093, 7'd1));
    send(1, 3'b001, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 0, mk(1, 0, 0, 6'd1, 32'h00500113, 7'd2));
    send(1, 3'b001, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 0, mk(1, 0, 0, 6'd2, 32'h00500193, 7'd3));
    send(1, 3'b111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 0, mk(0, 1, 0, 6'd0, 32'h0, 7'd3));
    chk("full.ready_after_err", 32'(ifb.ready), 1);
    send(1, 3'b001, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, 0, mk(1, 0, 0, 6'd3, 32'h00500213, 7'd4));
    chk("full.ready", 32'(ifb.ready), 0);
    chk("full.busy",  32'(busy_b),    1);
    rd = 5'd5;
    valid_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("full.stall_ready", 32'(ifb.ready), 0);
    chk("full.stall_count", 32'(count_b),   4);
    fin(1, mk(0, 0, 1, 6'd0, 32'h0, 7'd4));
    @(negedge clk);
    chk("full.busy_after", 32'(busy_b), 0);

    // Reset right after an accept: the pending write must vanish.
    start_s(0);
    kind = 3'b001; rd = 5'd1; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; imm = 13'd5;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid_a = 1'b0;
    @(negedge clk);
    chk("mid_rst.we",    32'(we_a),    0);
    chk("mid_rst.count", 32'(count_a), 0);
    chk("mid_rst.busy",  32'(busy_a),  0);
    chk("mid_rst.data",  data_a,       0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("qa.empty", 32'(qa.size()), 0);
    chk("qb.empty", 32'(qb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
